emif_cal_msg_capture: RTL

EMIF_CAL_MSG_CAPTURE -- requirements
Module: emif_cal_msg_capture

---
 rtl/emif_cal_msg_pkg.sv | 32 +++
 rtl/emif_cal_msg_capture_if.sv | 31 +++
 rtl/emif_cal_msg_fifo.sv | 53 +++++
 rtl/emif_cal_msg_capture.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/emif_cal_msg_pkg.sv
// emif_cal_msg_pkg: shared types for the calibration message capture block.
// Provides the FIFO entry struct, ENTRY_W, FSM states and the default mailbox base.
// ENTRY_W and the entry layout depend on EMIF_CAL_MSG_TIMESTAMP_EN.
package emif_cal_msg_pkg;

    localparam logic [19:0] MBOX_BASE_ADDR_DEFAULT = 20'h1_0000;

`ifdef EMIF_CAL_MSG_TIMESTAMP_EN
    localparam int ENTRY_W = 27;

    typedef struct packed {
        logic        eom;
        logic [1:0]  ch;
        logic [7:0]  chr;
        logic [15:0] ts;
    } entry_t;
`else
    localparam int ENTRY_W = 11;

    typedef struct packed {
        logic       eom;
        logic [1:0] ch;
        logic [7:0] chr;
    } entry_t;
`endif

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UNPACK = 1'b1
    } state_e;

endpackage

// File: rtl/emif_cal_msg_capture_if.sv
// emif_cal_msg_capture_if: cal-bus write port plus the message stream handshake.
// master: bus writer and stream consumer; slave: the capture block.
interface emif_cal_msg_capture_if;
    import emif_cal_msg_pkg::*;

    logic               cal_bus_avl_write;
    logic [19:0]        cal_bus_avl_address;
    logic [31:0]        cal_bus_avl_write_data;
    logic               msg_valid;
    logic               msg_ready;
    logic [ENTRY_W-1:0] msg_data;

    modport master (
        output cal_bus_avl_write,
        output cal_bus_avl_address,
        output cal_bus_avl_write_data,
        input  msg_valid,
        input  msg_data,
        output msg_ready
    );

    modport slave (
        input  cal_bus_avl_write,
        input  cal_bus_avl_address,
        input  cal_bus_avl_write_data,
        output msg_valid,
        output msg_data,
        input  msg_ready
    );

endinterface

// File: rtl/emif_cal_msg_fifo.sv
// emif_cal_msg_fifo: synchronous FIFO, width W, depth DEPTH (power of 2).
// Ports: clk, rst (async high), push/din, pop/dout, full, empty; dout is 0 when empty.
module emif_cal_msg_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/emif_cal_msg_capture.sv
// emif_cal_msg_capture: unpacks calibration mailbox words into a char FIFO.
// Ports: cal_bus_clk, cal_bus_reset, bus (cal-bus writes + msg stream),
// msg_count, drop_count, overflow. Option: EMIF_CAL_MSG_TIMESTAMP_EN.
module emif_cal_msg_capture
    import emif_cal_msg_pkg::*;
#(
    parameter int          NUM_CH         = 2,
    parameter int          FIFO_DEPTH     = 64,
    parameter logic [19:0] MBOX_BASE_ADDR = MBOX_BASE_ADDR_DEFAULT
) (
    input  logic                  cal_bus_clk,
    input  logic                  cal_bus_reset,
    emif_cal_msg_capture_if.slave bus,
    output logic [15:0]           msg_count,
    output logic [15:0]           drop_count,
    output logic                  overflow
);
    localparam logic [19:0] LAST_ADDR = MBOX_BASE_ADDR + 20'(NUM_CH - 1);

    state_e      state;
    logic [31:0] cur_word;
    logic [31:0] pend_word;
    logic [1:0]  cur_ch;
    logic [1:0]  pend_ch;
    logic [1:0]  byte_idx;
    logic        pend_vld;
    logic        acc;
    logic [1:0]  acc_ch;
    logic        is_term;
    logic        is_last;
    logic        ld_acc;
    logic        ld_pend;
    logic        pend_fill;
    logic        word_drop;
    logic        byte_drop;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [16:0] drop_sum;
    entry_t      ent;

`ifdef EMIF_CAL_MSG_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] cur_ts;
    logic [15:0] pend_ts;
`endif

    assign acc = bus.cal_bus_avl_write
              && (bus.cal_bus_avl_address >= MBOX_BASE_ADDR)
              && (bus.cal_bus_avl_address <= LAST_ADDR);
    assign acc_ch = 2'(bus.cal_bus_avl_address - MBOX_BASE_ADDR);

    // The byte being emitted always sits in the low lane of cur_word.
    assign is_term = (cur_word[7:0] == 8'h00);
    assign is_last = (state == ST_UNPACK) && (is_term || byte_idx == 2'd3);

    // Only one word may wait behind the one being unpacked.
    assign word_drop = acc && pend_vld;
    assign pend_fill = acc && !pend_vld && (state == ST_UNPACK) && !is_last;
    assign ld_pend   = is_last && pend_vld;
    assign ld_acc    = acc && ((state == ST_IDLE) || (is_last && !pend_vld));

    assign push      = (state == ST_UNPACK);
    assign pop       = bus.msg_valid && bus.msg_ready;
    assign byte_drop = push && full && !pop;
    assign drop_sum  = {1'b0, drop_count} + 17'(word_drop) + 17'(byte_drop);

    always_comb begin
        ent     = '0;
        ent.eom = is_term;
        ent.ch  = cur_ch;
        ent.chr = cur_word[7:0];
`ifdef EMIF_CAL_MSG_TIMESTAMP_EN
        ent.ts  = cur_ts;
`endif
    end

    always_ff @(posedge cal_bus_clk or posedge cal_bus_reset) begin
        if (cal_bus_reset) begin
            state     <= ST_IDLE;
            cur_word  <= '0;
            cur_ch    <= '0;
            byte_idx  <= '0;
            pend_vld  <= 1'b0;
            pend_word <= '0;
            pend_ch   <= '0;
        end else begin
            if (ld_acc) begin
                cur_word <= bus.cal_bus_avl_write_data;
                cur_ch   <= acc_ch;
                byte_idx <= '0;
            end else if (ld_pend) begin
                cur_word <= pend_word;
                cur_ch   <= pend_ch;
                byte_idx <= '0;
            end else if (state == ST_UNPACK) begin
                cur_word <= cur_word >> 8;
                byte_idx <= byte_idx + 2'd1;
            end
            if (ld_acc || ld_pend) state <= ST_UNPACK;
            else if (is_last)      state <= ST_IDLE;
            if (pend_fill) begin
                pend_vld  <= 1'b1;
                pend_word <= bus.cal_bus_avl_write_data;
                pend_ch   <= acc_ch;
            end else if (ld_pend) begin
                pend_vld  <= 1'b0;
            end
        end
    end

    // A terminator counts as a message even when its push is dropped.
    always_ff @(posedge cal_bus_clk or posedge cal_bus_reset) begin
        if (cal_bus_reset) begin
            msg_count  <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push && is_term) msg_count <= msg_count + 16'd1;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (word_drop || byte_drop) overflow <= 1'b1;
        end
    end

`ifdef EMIF_CAL_MSG_TIMESTAMP_EN
    always_ff @(posedge cal_bus_clk or posedge cal_bus_reset) begin
        if (cal_bus_reset) begin
            ts_cnt  <= '0;
            cur_ts  <= '0;
            pend_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (ld_acc)       cur_ts  <= ts_cnt;
            else if (ld_pend) cur_ts  <= pend_ts;
            if (pend_fill)    pend_ts <= ts_cnt;
        end
    end
`endif

    emif_cal_msg_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (cal_bus_clk),
        .rst   (cal_bus_reset),
        .push  (push),
        .din   (ent),
        .pop   (pop),
        .dout  (bus.msg_data),
        .full  (full),
        .empty (empty)
    );

    assign bus.msg_valid = !empty;

endmodule
